// File: rtl/traffic_lamp_monitor.sv
// traffic_lamp_monitor: checks the controller lamp requests for legality, order and timing,
// drives the physical lamps, and falls back to a blinking safe pattern on fault. Optional: MONITOR_STATS_EN.
module traffic_lamp_monitor #(
  parameter int unsigned ILLEGAL_HOLD = 2,
  parameter int unsigned MIN_WARN     = 2,
  parameter int unsigned MAX_PHASE    = 30,
  parameter int unsigned CNT_W        = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tc_timebase_i,
  input  logic        g_car_i,
  input  logic        y_car_i,
  input  logic        r_car_i,
  input  logic        g_pedes_i,
  input  logic        r_pedes_i,
  input  logic        fault_clr_i,
  output logic        lamp_g_car_o,
  output logic        lamp_y_car_o,
  output logic        lamp_r_car_o,
  output logic        lamp_g_pedes_o,
  output logic        lamp_r_pedes_o,
  output logic        fault_o,
  output logic [2:0]  fault_code_o,
  output logic [1:0]  phase_o
`ifdef MONITOR_STATS_EN
  ,
  output logic [15:0] cycle_cnt_o,
  output logic [7:0]  fault_cnt_o
`endif
);

  localparam int unsigned PAT_W   = 5;
  localparam int unsigned HOLD_W  = 4;
  localparam int unsigned HOLD_CW = HOLD_W + 1;

  // Pattern bit order: {g_car, y_car, r_car, g_pedes, r_pedes}
  localparam logic [PAT_W-1:0] PAT_ALL_RED  = 5'b00101;
  localparam logic [PAT_W-1:0] PAT_CAR_GO   = 5'b10001;
  localparam logic [PAT_W-1:0] PAT_CAR_WARN = 5'b01001;
  localparam logic [PAT_W-1:0] PAT_PED_GO   = 5'b00110;

  localparam logic [HOLD_W-1:0]  HOLD_SAT = '1;
  localparam logic [HOLD_CW-1:0] HOLD_LIM = HOLD_CW'(ILLEGAL_HOLD);
  localparam logic [CNT_W-1:0]   TCNT_SAT = CNT_W'(MAX_PHASE + 1);
  localparam logic [CNT_W-1:0]   TCNT_MAX = CNT_W'(MAX_PHASE);
  localparam logic [CNT_W-1:0]   WARN_MIN = CNT_W'(MIN_WARN);

  localparam logic [2:0] CODE_NONE       = 3'd0;
  localparam logic [2:0] CODE_ILLEGAL    = 3'd1;
  localparam logic [2:0] CODE_ORDER      = 3'd2;
  localparam logic [2:0] CODE_WARN_SHORT = 3'd3;
  localparam logic [2:0] CODE_TIMEOUT    = 3'd4;

  typedef enum logic [1:0] {MON_INIT, MON_RUN, MON_FAULT} mon_state_e;
  typedef enum logic [1:0] {PH_ALL_RED, PH_CAR_GO, PH_CAR_WARN, PH_PED_GO} phase_e;

  mon_state_e        state_q, state_d;
  phase_e            phase_q, phase_d, pat_phase;
  logic [PAT_W-1:0]  pat_q, lamp_q, lamp_d;
  logic              tick_q, clr_q;
  logic [HOLD_W-1:0] ill_q, ill_d;
  logic [HOLD_CW-1:0] ill_inc;
  logic [CNT_W-1:0]  tcnt_q, tcnt_d;
  logic              fault_q, fault_d;
  logic [2:0]        code_q, code_d, det_code;
  logic              pat_legal, trans_ok, ill_hit, phase_chg;

  // Single input register stage; every check below looks at these copies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q  <= PAT_ALL_RED;
      tick_q <= 1'b0;
      clr_q  <= 1'b0;
    end else begin
      pat_q  <= {g_car_i, y_car_i, r_car_i, g_pedes_i, r_pedes_i};
      tick_q <= tc_timebase_i;
      clr_q  <= fault_clr_i;
    end
  end

  always_comb begin
    pat_legal = 1'b1;
    pat_phase = PH_ALL_RED;
    case (pat_q)
      PAT_ALL_RED:  pat_phase = PH_ALL_RED;
      PAT_CAR_GO:   pat_phase = PH_CAR_GO;
      PAT_CAR_WARN: pat_phase = PH_CAR_WARN;
      PAT_PED_GO:   pat_phase = PH_PED_GO;
      default:      pat_legal = 1'b0;
    endcase
  end

  always_comb begin
    trans_ok = 1'b0;
    case (phase_q)
      PH_CAR_GO:   trans_ok = (pat_phase == PH_CAR_WARN);
      PH_CAR_WARN: trans_ok = (pat_phase == PH_PED_GO) || (pat_phase == PH_ALL_RED);
      PH_ALL_RED:  trans_ok = (pat_phase == PH_PED_GO) || (pat_phase == PH_CAR_GO);
      PH_PED_GO:   trans_ok = (pat_phase == PH_CAR_GO) || (pat_phase == PH_ALL_RED);
      default:     trans_ok = 1'b0;
    endcase
  end

  // Fault detection, highest priority first; order/timing checks only once a phase is known
  always_comb begin
    ill_inc   = HOLD_CW'(ill_q) + HOLD_CW'(1);
    ill_hit   = !pat_legal && (ill_inc >= HOLD_LIM);
    phase_chg = pat_legal && (pat_phase != phase_q);
    det_code  = CODE_NONE;
    if (ill_hit) begin
      det_code = CODE_ILLEGAL;
    end else if (state_q == MON_RUN) begin
      if (phase_chg && !trans_ok) begin
        det_code = CODE_ORDER;
      end else if (phase_chg && (phase_q == PH_CAR_WARN) && (tcnt_q < WARN_MIN)) begin
        det_code = CODE_WARN_SHORT;
      end else if (tcnt_q > TCNT_MAX) begin
        det_code = CODE_TIMEOUT;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    fault_d = fault_q;
    code_d  = code_q;
    tcnt_d  = tcnt_q;
    ill_d   = pat_legal ? '0 : ((ill_q == HOLD_SAT) ? ill_q : ill_inc[HOLD_W-1:0]);
    case (state_q)
      MON_INIT: begin
        if (pat_legal) begin
          state_d = MON_RUN;
          phase_d = pat_phase;
          tcnt_d  = '0;
        end
      end
      MON_RUN: begin
        if (phase_chg) begin
          phase_d = pat_phase;
          tcnt_d  = '0;
        end else if (tick_q && (tcnt_q != TCNT_SAT)) begin
          tcnt_d = tcnt_q + CNT_W'(1);
        end
      end
      MON_FAULT: begin
        tcnt_d = '0;
        // A detection in the same cycle keeps the fault latched
        if (clr_q && !ill_hit) begin
          state_d = MON_INIT;
          phase_d = PH_ALL_RED;
          fault_d = 1'b0;
          code_d  = CODE_NONE;
          ill_d   = '0;
        end
      end
      default: state_d = MON_INIT;
    endcase
    if ((state_q != MON_FAULT) && (det_code != CODE_NONE)) begin
      state_d = MON_FAULT;
      phase_d = phase_q;
      fault_d = 1'b1;
      code_d  = det_code;
      tcnt_d  = '0;
    end
  end

  // Healthy: copy raw requests (one clock lag). Fault: car yellow blinks from 1, pedestrian red.
  always_comb begin
    lamp_d = {g_car_i, y_car_i, r_car_i, g_pedes_i, r_pedes_i};
    if (state_d == MON_FAULT) begin
      lamp_d = {1'b0, (state_q == MON_FAULT) ? (lamp_q[3] ^ tick_q) : 1'b1, 3'b001};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MON_INIT;
      phase_q <= PH_ALL_RED;
      fault_q <= 1'b0;
      code_q  <= CODE_NONE;
      tcnt_q  <= '0;
      ill_q   <= '0;
      lamp_q  <= PAT_ALL_RED;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      tcnt_q  <= tcnt_d;
      ill_q   <= ill_d;
      lamp_q  <= lamp_d;
    end
  end

  assign lamp_g_car_o   = lamp_q[4];
  assign lamp_y_car_o   = lamp_q[3];
  assign lamp_r_car_o   = lamp_q[2];
  assign lamp_g_pedes_o = lamp_q[1];
  assign lamp_r_pedes_o = lamp_q[0];
  assign fault_o        = fault_q;
  assign fault_code_o   = code_q;
  assign phase_o        = phase_q;

`ifdef MONITOR_STATS_EN
  logic [15:0] cycle_cnt_q;
  logic [7:0]  fault_cnt_q;
  logic        car_go_entry, fault_entry;

  assign car_go_entry = (state_q == MON_RUN) && (det_code == CODE_NONE) && phase_chg &&
                        (pat_phase == PH_CAR_GO);
  assign fault_entry  = (state_q != MON_FAULT) && (det_code != CODE_NONE);

  // Statistics survive fault clears; only reset zeroes them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      fault_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 16'(car_go_entry);
      if (fault_entry && (fault_cnt_q != 8'hFF)) begin
        fault_cnt_q <= fault_cnt_q + 8'd1;
      end
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
  assign fault_cnt_o = fault_cnt_q;
`endif

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Bench for traffic_lamp_monitor: directed scenarios plus random controller traffic,
// each cycle compared against a phase-level reference model.
module tb_traffic_lamp_monitor;

  localparam int HOLD = 2;
  localparam int MINW = 2;
  localparam int MAXP = 30;
  localparam int M_INIT = 0, M_RUN = 1, M_FAULT = 2;

  localparam logic [4:0] P_RED  = 5'b00101;
  localparam logic [4:0] P_GO   = 5'b10001;
  localparam logic [4:0] P_WARN = 5'b01001;
  localparam logic [4:0] P_PED  = 5'b00110;
  localparam logic [4:0] P_BAD  = 5'b10010;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] in_pat;
  logic       in_tick, in_clr;
  logic       l_g, l_y, l_r, l_gp, l_rp, fault;
  logic [2:0] code;
  logic [1:0] phase;
  logic [4:0] lamps;
`ifdef MONITOR_STATS_EN
  logic [15:0] cycle_cnt;
  logic [7:0]  fault_cnt;
`endif

  assign lamps = {l_g, l_y, l_r, l_gp, l_rp};

  traffic_lamp_monitor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tc_timebase_i  (in_tick),
    .g_car_i        (in_pat[4]),
    .y_car_i        (in_pat[3]),
    .r_car_i        (in_pat[2]),
    .g_pedes_i      (in_pat[1]),
    .r_pedes_i      (in_pat[0]),
    .fault_clr_i    (in_clr),
    .lamp_g_car_o   (l_g),
    .lamp_y_car_o   (l_y),
    .lamp_r_car_o   (l_r),
    .lamp_g_pedes_o (l_gp),
    .lamp_r_pedes_o (l_rp),
    .fault_o        (fault),
    .fault_code_o   (code),
    .phase_o        (phase)
`ifdef MONITOR_STATS_EN
    ,
    .cycle_cnt_o    (cycle_cnt),
    .fault_cnt_o    (fault_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what the monitor has seen so far and what it should show
  logic [4:0] m_seen_pat, m_lamps;
  bit         m_seen_tick, m_seen_clr, m_fault, m_blink;
  int         m_mode, m_phase, m_ticks, m_illrun, m_code, m_cycles, m_faults;

  function automatic int phase_of(input logic [4:0] p);
    case (p)
      P_RED:   return 0;
      P_GO:    return 1;
      P_WARN:  return 2;
      P_PED:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic bit may_follow(input int from, input int to);
    case (from)
      0:       return (to == 3) || (to == 1);
      1:       return (to == 2);
      2:       return (to == 3) || (to == 0);
      default: return (to == 1) || (to == 0);
    endcase
  endfunction

  task automatic model_reset();
    m_seen_pat = P_RED; m_seen_tick = 0; m_seen_clr = 0;
    m_mode = M_INIT; m_phase = 0; m_ticks = 0; m_illrun = 0;
    m_fault = 0; m_code = 0; m_lamps = P_RED; m_blink = 0;
    m_cycles = 0; m_faults = 0;
  endtask

  task automatic model_edge();
    int  ph, fcode;
    bit  was_fault;
    ph = phase_of(m_seen_pat);
    was_fault = (m_mode == M_FAULT);
    if (ph < 0) m_illrun++; else m_illrun = 0;
    fcode = 0;
    if (ph < 0 && m_illrun >= HOLD) fcode = 1;
    else if (m_mode == M_RUN) begin
      if (ph >= 0 && ph != m_phase && !may_follow(m_phase, ph)) fcode = 2;
      else if (ph >= 0 && ph != m_phase && m_phase == 2 && m_ticks < MINW) fcode = 3;
      else if (m_ticks > MAXP) fcode = 4;
    end
    if (!was_fault && fcode != 0) begin
      m_mode = M_FAULT; m_fault = 1; m_code = fcode; m_ticks = 0;
      if (m_faults < 255) m_faults++;
    end else if (m_mode == M_INIT) begin
      if (ph >= 0) begin m_mode = M_RUN; m_phase = ph; m_ticks = 0; end
    end else if (m_mode == M_RUN) begin
      if (ph >= 0 && ph != m_phase) begin
        if (ph == 1) m_cycles++;
        m_phase = ph; m_ticks = 0;
      end else if (m_seen_tick && m_ticks <= MAXP) m_ticks++;
    end else if (m_seen_clr && fcode != 1) begin
      m_mode = M_INIT; m_fault = 0; m_code = 0; m_illrun = 0; m_phase = 0;
    end
    if (m_mode == M_FAULT) begin
      m_blink = was_fault ? (m_blink ^ m_seen_tick) : 1'b1;
      m_lamps = {1'b0, m_blink, 3'b001};
    end else begin
      m_lamps = in_pat;
    end
    m_seen_pat = in_pat; m_seen_tick = in_tick; m_seen_clr = in_clr;
  endtask

  task automatic compare_all();
    chk("lamps", 32'(lamps), 32'(m_lamps));
    chk("fault", 32'(fault), 32'(m_fault));
    chk("code",  32'(code),  32'(m_code));
    chk("phase", 32'(phase), 32'(m_phase));
`ifdef MONITOR_STATS_EN
    chk("cycle_cnt", 32'(cycle_cnt), 32'(m_cycles % 65536));
    chk("fault_cnt", 32'(fault_cnt), 32'(m_faults));
`endif
  endtask

  task automatic cycle(input logic [4:0] p, input bit t, input bit c);
    in_pat = p; in_tick = t; in_clr = c;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Drive a pattern for n timebase ticks, one tick every second clock
  task automatic hold(input logic [4:0] p, input int ticks);
    for (int i = 0; i < ticks; i++) begin
      cycle(p, 1'b0, 1'b0);
      cycle(p, 1'b1, 1'b0);
    end
  endtask

  task automatic clear_fault();
    cycle(P_RED, 1'b0, 1'b0);
    cycle(P_RED, 1'b0, 1'b1);
    cycle(P_RED, 1'b0, 1'b0);
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_code",  32'(code),  32'd0);
  endtask

  logic [4:0] pats [4];

  initial begin
    int cur, nxt, r;
    logic [4:0] p;
    bit t, c;
    pats[0] = P_RED; pats[1] = P_GO; pats[2] = P_WARN; pats[3] = P_PED;
    rst_n = 1'b0; in_pat = P_RED; in_tick = 1'b0; in_clr = 1'b0;
    model_reset();
    #12;
    chk("rst_lamps", 32'(lamps), 32'(P_RED));
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_code",  32'(code),  32'd0);
    chk("rst_phase", 32'(phase), 32'd0);
    #15 rst_n = 1'b1;

    // Normal cycle: ALL_RED, CAR_GO 10, CAR_WARN 2, PED_GO 10, CAR_GO
    hold(P_RED, 2);
    hold(P_GO, 10);
    chk("seq_phase_go", 32'(phase), 32'd1);
    hold(P_WARN, 2);
    chk("seq_phase_warn", 32'(phase), 32'd2);
    hold(P_PED, 10);
    chk("seq_phase_ped", 32'(phase), 32'd3);
    hold(P_GO, 2);
    chk("seq_phase_go2", 32'(phase), 32'd1);
    chk("seq_lamps", 32'(lamps), 32'(P_GO));
    chk("seq_fault", 32'(fault), 32'd0);

    // One-clock illegal glitch passes, two clocks latches code 1
    cycle(P_BAD, 1'b0, 1'b0);
    chk("glitch_lamps", 32'(lamps), 32'(P_BAD));
    hold(P_GO, 1);
    chk("glitch_fault", 32'(fault), 32'd0);
    cycle(P_BAD, 1'b0, 1'b0);
    cycle(P_BAD, 1'b0, 1'b0);
    cycle(P_GO, 1'b0, 1'b0);
    chk("ill_fault", 32'(fault), 32'd1);
    chk("ill_code",  32'(code),  32'd1);
    chk("ill_safe",  32'(lamps), 32'(P_WARN));
    clear_fault();
    hold(P_RED, 1);
    hold(P_GO, 2);
    chk("reaccept_phase", 32'(phase), 32'd1);

    // CAR_GO straight to PED_GO
    hold(P_PED, 1);
    chk("order_code", 32'(code), 32'd2);
    chk("order_safe", 32'(lamps), 32'(P_WARN));
    hold(P_PED, 3);
    chk("order_mask", 32'(lamps & 5'b10111), 32'd1);
    clear_fault();

    // CAR_WARN held only one tick
    hold(P_RED, 1);
    hold(P_GO, 2);
    hold(P_WARN, 1);
    hold(P_PED, 1);
    chk("short_code", 32'(code), 32'd3);
    clear_fault();

    // 30 ticks is fine, 31 ticks times out
    hold(P_RED, 1);
    hold(P_GO, 30);
    hold(P_WARN, 2);
    chk("max_ok_fault", 32'(fault), 32'd0);
    hold(P_PED, 31);
    chk("max_edge_fault", 32'(fault), 32'd0);
    for (int i = 0; i < 3; i++) cycle(P_PED, 1'b0, 1'b0);
    chk("timeout_code", 32'(code), 32'd4);

    // Clear while an illegal pattern is being detected is refused
    cycle(P_BAD, 1'b0, 1'b0);
    cycle(P_BAD, 1'b0, 1'b0);
    cycle(P_BAD, 1'b0, 1'b1);
    cycle(P_BAD, 1'b0, 1'b0);
    cycle(P_RED, 1'b0, 1'b0);
    chk("clr_blocked_fault", 32'(fault), 32'd1);
    chk("clr_blocked_code",  32'(code),  32'd4);
    clear_fault();

    // Asynchronous reset in the middle of PED_GO
    hold(P_RED, 1);
    hold(P_PED, 3);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_lamps", 32'(lamps), 32'(P_RED));
    chk("arst_phase", 32'(phase), 32'd0);
    chk("arst_fault", 32'(fault), 32'd0);
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Random controller traffic with occasional misbehaviour
    cur = 3;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      t = ($urandom_range(0, 2) == 0);
      c = (m_mode == M_FAULT) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0);
      if (r < 6) begin
        do nxt = $urandom_range(0, 3); while (!may_follow(cur, nxt));
        cur = nxt;
      end else if (r < 8) begin
        cur = $urandom_range(0, 3);
      end
      p = (r >= 97) ? 5'($urandom) : pats[cur];
      cycle(p, t, c);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
